// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the 3-source round-robin bus arbiter
package bus_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef logic [1:0] owner_t;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Successor in the 0 -> 1 -> 2 -> 0 ring
  function automatic owner_t next_idx(input owner_t x);
    next_idx = (x >= owner_t'(NUM_REQ - 1)) ? owner_t'(0) : owner_t'(x + owner_t'(1));
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input owner_t x);
    case (x)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin pick among three requesters
// Priority runs last+1, last+2, last; the first asserted request wins.
module rr_pick3 import bus_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] i_req,
  input  owner_t             i_last,
  output logic               o_pick_valid,
  output owner_t             o_pick_idx
);

  owner_t w_c1;
  owner_t w_c2;
  owner_t w_c3;

  assign w_c1 = next_idx(i_last);
  assign w_c2 = next_idx(w_c1);
  assign w_c3 = next_idx(w_c2);

  always_comb begin
    o_pick_valid = 1'b1;
    o_pick_idx   = w_c1;
    if (i_req[w_c1]) begin
      o_pick_idx = w_c1;
    end else if (i_req[w_c2]) begin
      o_pick_idx = w_c2;
    end else if (i_req[w_c3]) begin
      o_pick_idx = w_c3;
    end else begin
      o_pick_valid = 1'b0;
    end
  end

endmodule

// File: rtl/bus_arbiter_3.sv
// rtl/bus_arbiter_3.sv - round-robin grant sequencer and registered bus for three sources
// Define BURST_LIMIT_EN to cap each tenure at MAX_BURST captures when others are waiting.
module bus_arbiter_3 import bus_arb_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [WIDTH-1:0]   i_data0,
  input  logic [WIDTH-1:0]   i_data1,
  input  logic [WIDTH-1:0]   i_data2,
  output logic [NUM_REQ-1:0] o_grant,
  output owner_t             o_owner,
  output logic [WIDTH-1:0]   o_bus_out,
  output logic               o_bus_valid
);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_grant;
  owner_t             r_owner;
  owner_t             r_last;
  logic [WIDTH-1:0]   r_bus;
  logic               r_valid;

  owner_t             w_pick_last;
  owner_t             w_pick_idx;
  logic               w_pick_valid;
  logic               w_own_req;
  logic [WIDTH-1:0]   w_sel_data;

  // While busy the owner is the most recent winner, so it ranks lowest in the re-pick
  assign w_pick_last = (r_state == ARB_BUSY) ? r_owner : r_last;
  assign w_own_req   = i_req[r_owner];

  rr_pick3 u_pick (
    .i_req        (i_req),
    .i_last       (w_pick_last),
    .o_pick_valid (w_pick_valid),
    .o_pick_idx   (w_pick_idx)
  );

  always_comb begin
    w_sel_data = i_data0;
    case (r_owner)
      2'd1:    w_sel_data = i_data1;
      2'd2:    w_sel_data = i_data2;
      default: w_sel_data = i_data0;
    endcase
  end

`ifdef BURST_LIMIT_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_others;
  logic             w_burst_done;

  assign w_others     = |(i_req & ~onehot(r_owner));
  assign w_burst_done = (r_cnt == CNT_W'(MAX_BURST - 1));
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= owner_t'(2);
      r_bus   <= '0;
      r_valid <= 1'b0;
`ifdef BURST_LIMIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_valid <= 1'b0;
          if (w_pick_valid) begin
            r_grant <= onehot(w_pick_idx);
            r_owner <= w_pick_idx;
            r_state <= ARB_BUSY;
`ifdef BURST_LIMIT_EN
            r_cnt   <= '0;
`endif
          end else begin
            r_grant <= '0;
          end
        end
        default: begin
          if (w_own_req) begin
            r_bus   <= w_sel_data;
            r_valid <= 1'b1;
`ifdef BURST_LIMIT_EN
            if (w_burst_done) begin
              r_cnt <= '0;
              if (w_others) begin
                r_last  <= r_owner;
                r_grant <= onehot(w_pick_idx);
                r_owner <= w_pick_idx;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
`endif
          end else begin
            // Release: hand over on this same edge when anyone else is waiting
            r_last  <= r_owner;
            r_valid <= 1'b0;
`ifdef BURST_LIMIT_EN
            r_cnt   <= '0;
`endif
            if (w_pick_valid) begin
              r_grant <= onehot(w_pick_idx);
              r_owner <= w_pick_idx;
            end else begin
              r_grant <= '0;
              r_state <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($onehot0(r_grant));
      assert (MAX_BURST >= 1);
    end
  end

  assign o_grant     = r_grant;
  assign o_owner     = r_owner;
  assign o_bus_out   = r_bus;
  assign o_bus_valid = r_valid;

endmodule
